// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and datapath select encodings shared by the RV32I control path
package riscv_ctrl_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  // Opcodes that execute normally; SYSTEM is recognised separately because it halts
  function automatic logic is_known(input logic [6:0] op);
    return op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE};
  endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode/funct3/funct7[5] to the ALU operation code
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);
  // Only SRAI among immediates uses funct7[5]; elsewhere that bit is immediate data
  always_comb
    alu_op = opcode == OPC_OP     ? {funct7_5, funct3} :
             opcode == OPC_OP_IMM ? {funct7_5 & (funct3 == 3'b101), funct3} :
                                    4'b0000;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);
  state_e     state_q, state_d;
  logic       halted_q, halted_d, illegal_q, illegal_d;
  logic [6:0] opc;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_fence, is_op_imm;
  logic [2:0] imm_k;
  logic [1:0] a_k;
  logic       b_k;
  logic [3:0] alu_op_dec;
  logic       unused_instr;

  assign opc          = instr[6:0];
  assign is_load      = opc == OPC_LOAD;
  assign is_store     = opc == OPC_STORE;
  assign is_branch    = opc == OPC_BRANCH;
  assign is_jal       = opc == OPC_JAL;
  assign is_jalr      = opc == OPC_JALR;
  assign is_lui       = opc == OPC_LUI;
  assign is_auipc     = opc == OPC_AUIPC;
  assign is_fence     = opc == OPC_FENCE;
  assign is_op_imm    = opc == OPC_OP_IMM;
  assign imm_k        = is_store ? IMM_S : is_branch ? IMM_B : is_jal ? IMM_J :
                        (is_lui | is_auipc) ? IMM_U : IMM_I;
  assign a_k          = is_lui ? A_ZERO : is_auipc ? A_PC : A_RS1;
  assign b_k          = is_op_imm | is_load | is_store | is_jalr | is_lui | is_auipc;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign state   = rst ? 3'd0 : state_q;
  assign halted  = ~rst & halted_q;
  assign illegal = ~rst & illegal_q;

  alu_op_decode u_alu_op_decode (
    .opcode   (opc),
    .funct3   (instr[14:12]),
    .funct7_5 (instr[30]),
    .alu_op   (alu_op_dec)
  );

  // State register and sticky halt/illegal flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and per-state strobes; everything is held at zero while rst is high
  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    imm_sel      = IMM_I;
    alu_a_sel    = A_RS1;
    alu_b_sel    = 1'b0;
    alu_op       = 4'b0000;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        imm_sel   = imm_k;
        state_d   = is_known(opc) ? S_EXEC : S_HALT;
        halted_d  = halted_q | (opc == OPC_SYSTEM);
        illegal_d = illegal_q | (~is_known(opc) & (opc != OPC_SYSTEM));
      end
      S_EXEC: begin
        imm_sel   = imm_k;
        alu_a_sel = a_k;
        alu_b_sel = b_k;
        alu_op    = alu_op_dec;
        pc_we     = is_branch | is_fence;
        pc_sel    = (is_branch & branch_taken) ? PC_IMM : PC_PLUS4;
        state_d   = (is_load | is_store) ? S_MEM : (is_branch | is_fence) ? S_FETCH : S_WB;
      end
      S_MEM: begin
        imm_sel      = imm_k;
        alu_a_sel    = a_k;
        alu_b_sel    = b_k;
        alu_op       = alu_op_dec;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        pc_we        = mem_ready & is_store;
        state_d      = ~mem_ready ? S_MEM : is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        imm_sel = imm_k;
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        wb_sel  = is_load ? WB_MEM : (is_jal | is_jalr) ? WB_PC4 : WB_ALU;
        pc_sel  = is_jal ? PC_IMM : is_jalr ? PC_ALU : PC_PLUS4;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    if (rst) begin
      {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel,
       alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel} = '0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vector table plus hand sequences for stalls, halts and reset
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, reg_we, halted, illegal;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel;
  logic [2:0]  imm_sel, state;
  logic [3:0]  alu_op;

  int tests = 0;
  int fails = 0;

  logic [2:0] o_imm;
  logic [1:0] o_a, o_pcs, o_wbs;
  logic       o_b, o_mw;
  logic [3:0] o_op;
  int         o_cyc, o_rcnt, o_rcyc, o_memc;

  typedef struct {
    logic [31:0] ins;
    logic        bt;
    int          stall;
    int          cyc;
    logic [2:0]  imm;
    logic [1:0]  a;
    logic        b;
    logic [3:0]  op;
    logic [1:0]  pcs;
    int          rcnt;
    logic [1:0]  wbs;
    int          memc;
    logic        mw;
  } vec_t;

  vec_t v[15];

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input logic bt, input int stall);
    logic done;
    instr = ins;
    branch_taken = bt;
    mem_ready = 1'b1;
    do_reset();
    {o_imm, o_a, o_pcs, o_wbs, o_b, o_mw, o_op} = '0;
    o_cyc = 0; o_rcnt = 0; o_rcyc = 0; o_memc = 0;
    done = 1'b0;
    while (!done && o_cyc < 20) begin
      mem_ready = !(o_cyc >= 3 && o_cyc < 3 + stall);
      #1;
      o_cyc++;
      if (state == 3'd2) begin
        o_imm = imm_sel; o_a = alu_a_sel; o_b = alu_b_sel; o_op = alu_op;
      end
      if (mem_req && mem_addr_sel) begin
        o_memc++;
        o_mw = o_mw | mem_we;
      end
      if (reg_we) begin
        o_rcnt++; o_rcyc = o_cyc; o_wbs = wb_sel;
      end
      if (pc_we) begin
        o_pcs = pc_sel; done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int busy;
    v[0]  = '{32'h00500093, 1'b0, 0, 4, 3'd0, 2'd0, 1'b1, 4'h0, 2'd0, 1, 2'd0, 0, 1'b0};
    v[1]  = '{32'h002081B3, 1'b0, 0, 4, 3'd0, 2'd0, 1'b0, 4'h0, 2'd0, 1, 2'd0, 0, 1'b0};
    v[2]  = '{32'h402081B3, 1'b0, 0, 4, 3'd0, 2'd0, 1'b0, 4'h8, 2'd0, 1, 2'd0, 0, 1'b0};
    v[3]  = '{32'h40335293, 1'b0, 0, 4, 3'd0, 2'd0, 1'b1, 4'hD, 2'd0, 1, 2'd0, 0, 1'b0};
    v[4]  = '{32'h40000093, 1'b0, 0, 4, 3'd0, 2'd0, 1'b1, 4'h0, 2'd0, 1, 2'd0, 0, 1'b0};
    v[5]  = '{32'h00012083, 1'b0, 0, 5, 3'd0, 2'd0, 1'b1, 4'h0, 2'd0, 1, 2'd1, 1, 1'b0};
    v[6]  = '{32'h00012083, 1'b0, 3, 8, 3'd0, 2'd0, 1'b1, 4'h0, 2'd0, 1, 2'd1, 4, 1'b0};
    v[7]  = '{32'h00112223, 1'b0, 0, 4, 3'd1, 2'd0, 1'b1, 4'h0, 2'd0, 0, 2'd0, 1, 1'b1};
    v[8]  = '{32'h00208463, 1'b1, 0, 3, 3'd2, 2'd0, 1'b0, 4'h0, 2'd1, 0, 2'd0, 0, 1'b0};
    v[9]  = '{32'h00208463, 1'b0, 0, 3, 3'd2, 2'd0, 1'b0, 4'h0, 2'd0, 0, 2'd0, 0, 1'b0};
    v[10] = '{32'h010000EF, 1'b0, 0, 4, 3'd3, 2'd0, 1'b0, 4'h0, 2'd1, 1, 2'd2, 0, 1'b0};
    v[11] = '{32'h000100E7, 1'b0, 0, 4, 3'd0, 2'd0, 1'b1, 4'h0, 2'd2, 1, 2'd2, 0, 1'b0};
    v[12] = '{32'h123452B7, 1'b0, 0, 4, 3'd4, 2'd2, 1'b1, 4'h0, 2'd0, 1, 2'd0, 0, 1'b0};
    v[13] = '{32'h00001297, 1'b0, 0, 4, 3'd4, 2'd1, 1'b1, 4'h0, 2'd0, 1, 2'd0, 0, 1'b0};
    v[14] = '{32'h0FF0000F, 1'b0, 0, 3, 3'd0, 2'd0, 1'b0, 4'h0, 2'd0, 0, 2'd0, 0, 1'b0};

    @(negedge clk);
    #1;
    chk("reset outputs zero",
        {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel, alu_a_sel, alu_b_sel,
         alu_op, reg_we, wb_sel, halted, illegal, state}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run(v[i].ins, v[i].bt, v[i].stall);
      chk($sformatf("v%0d cycles", i), o_cyc, v[i].cyc);
      chk($sformatf("v%0d imm_sel", i), o_imm, v[i].imm);
      chk($sformatf("v%0d alu_a_sel", i), o_a, v[i].a);
      chk($sformatf("v%0d alu_b_sel", i), o_b, v[i].b);
      chk($sformatf("v%0d alu_op", i), o_op, v[i].op);
      chk($sformatf("v%0d pc_sel", i), o_pcs, v[i].pcs);
      chk($sformatf("v%0d reg_we count", i), o_rcnt, v[i].rcnt);
      chk($sformatf("v%0d wb_sel", i), o_wbs, v[i].wbs);
      chk($sformatf("v%0d reg_we cycle", i), o_rcyc, v[i].rcnt > 0 ? v[i].cyc : 0);
      chk($sformatf("v%0d mem data cycles", i), o_memc, v[i].memc);
      chk($sformatf("v%0d mem_we", i), o_mw, v[i].mw);
    end

    // Unsupported opcode halts with illegal set and goes quiet
    instr = 32'h0000007F;
    mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("illegal state", state, 3'd5);
    chk("illegal flag", illegal, 1'b1);
    chk("illegal no halted", halted, 1'b0);
    busy = 0;
    for (int c = 0; c < 6; c++) begin
      busy += int'(mem_req | pc_we | reg_we | ir_we);
      @(negedge clk);
      #1;
    end
    chk("halt strobes quiet", busy, 0);

    // ECALL after reset: reset clears illegal, then SYSTEM sets halted
    instr = 32'h00000073;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst forces flags low", {halted, illegal, state}, 5'h0);
    do_reset();
    #1;
    chk("ecall fetch mem_req", mem_req, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ecall state", state, 3'd5);
    chk("ecall halted", halted, 1'b1);
    chk("ecall illegal cleared", illegal, 1'b0);

    // Reset while a fetch is waiting for memory
    instr = 32'h00500093;
    mem_ready = 1'b0;
    do_reset();
    busy = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      busy += int'(mem_req && state == 3'd0 && !ir_we);
      @(negedge clk);
    end
    chk("fetch wait held", busy, 3);
    rst = 1'b1;
    #1;
    chk("rst drops mem_req", mem_req, 1'b0);
    @(negedge clk);
    #1;
    chk("rst next cycle mem_req", mem_req, 1'b0);
    chk("rst next cycle state", state, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("refetch mem_req", mem_req, 1'b1);
    chk("refetch ir_we", ir_we, 1'b1);
    @(negedge clk);
    #1;
    chk("refetch decode", state, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Drives the datapath enables, the immediate-type select consumed by the immediate generator, the ALU operand/op selects and the shared instruction/data memory handshake. It sits beside the datapath and reads the latched instruction register.

## Interface

Parameters:
- none

Ports:
- clk  in  1  core clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents; stable from DECODE onward
- branch_taken  in  1  datapath comparator result for current B-type funct3
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  store when 1, read when 0
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],0}
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  4  {funct7[5], funct3} or 4'b0000 (ADD)
- reg_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- halted  out  1  sticky; set by ECALL/EBREAK
- illegal  out  1  sticky; set by unsupported opcode
- state  out  3  current state, debug only

## Operation

- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 and go to DECODE. Otherwise hold.
- DECODE: one cycle. Classify opcode instr[6:0], then go to EXEC or HALT.
- EXEC (one cycle), by opcode:
  - OP 0110011: alu_b_sel=0, alu_op={f7[5],f3}.
  - OP-IMM 0010011: alu_b_sel=1, imm I; alu_op={f7[5]&(f3==101),f3}.
  - LOAD 0000011 / STORE 0100011: ADD, rs1+imm (I / S). Next state MEM.
  - BRANCH 1100011: imm B; pc_we=1, pc_sel = branch_taken ? 1 : 0. Next state FETCH.
  - JAL 1101111: imm J. Next state WB.
  - JALR 1100111: rs1+imm I, ADD. Next state WB.
  - LUI 0110111: zero+imm U. AUIPC 0010111: PC+imm U.
  - FENCE 0001111: no-op; pc_we=1, pc_sel=0. Next state FETCH.
  - All other non-load/store/branch/fence opcodes go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = (STORE). ALU selects held from EXEC.
  - On mem_ready: LOAD goes to WB; STORE asserts pc_we=1, pc_sel=0 and goes to FETCH.
- WB: reg_we=1, pc_we=1, then FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
- SYSTEM 1110011 or any unlisted opcode: DECODE goes to HALT.
  - SYSTEM sets halted; any unlisted opcode sets illegal.
  - HALT is terminal until rst. All strobes are 0 in HALT.
- imm_sel is valid from DECODE through the last state of the instruction.
- imm_sel, alu_a_sel and alu_b_sel are don't-care when unused; drive them 0.

## Timing

- Reset (rst high at an edge):
  - Next state FETCH; halted=0, illegal=0.
  - While rst is high, every output is forced to 0.
  - First mem_req occurs in the first cycle with rst low.
- Reset mid-access: mem_req drops in the rst cycle. The pending access is abandoned; memory must tolerate a withdrawn request.
- mem_req, mem_we and mem_addr_sel stay constant until mem_ready. Zero-wait memory (mem_ready in the same cycle as mem_req) is legal.
- Minimum cycles with zero-wait memory:
  - BRANCH, FENCE: 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - STORE: 4.
  - LOAD: 5.
- pc_we is asserted exactly once per retired instruction. reg_we is asserted at most once per retired instruction.
- Outputs are combinational from state and instr. The state register is the only sequential element besides the sticky flags.

## Structure

- Shared package riscv_ctrl_pkg holds:
  - Opcode constants.
  - State encoding.
  - Encodings for imm_sel, pc_sel, wb_sel and alu_a_sel.
- The existing immediate generator adopts the same imm_sel constants.
- One sub-module: alu_op_decode. It is combinational and maps opcode/funct3/funct7 to alu_op.

## Test plan

- ADDI x1,x0,5 (0x00500093), mem_ready tied 1 -> states F,D,X,WB; reg_we at cycle 4, imm_sel=0, alu_b_sel=1, alu_op=0000.
- LW with mem_ready low for 3 cycles in MEM -> mem_req=1, mem_addr_sel=1 held for 4 cycles; wb_sel=1, reg_we in following cycle; total 8 cycles.
- BEQ with branch_taken=1, then with 0 -> 3 cycles each; pc_sel=1 then 0; imm_sel=2; reg_we never asserted.
- JALR x1,0(x2) -> pc_sel=2, wb_sel=2, reg_we and pc_we in the same cycle.
- Opcode 0x7F, then ECALL 0x00000073 after reset -> illegal=1, state=5 with no further mem_req; after rst, halted=1 and illegal=0.
- rst asserted during a FETCH wait -> mem_req=0 next cycle, state=0; fetch restarts after rst is released.
